dm_responder: RTL and testbench
===============================

# dm_responder

Data-memory responder for the pipelined MIPS core: it sits on the core's external data bus and answers the byte-enabled load/store traffic the core initiates. It holds the word-organized data RAM, performs byte-merged writes, and returns read data combinationally. It also logs every committed store into a write-trace FIFO, drained by the simulation top-level through a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 3072: RAM size in 32-bit words; valid byte addresses are 0 to DEPTH*4-1.
- TRACE_DEPTH, 8: write-trace FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- m_data_addr  in  32  byte address from core; bits [1:0] ignored.
- m_data_wdata  in  32  store data, already lane-aligned by the core.
- m_data_byteen  in  4  byte-lane write enables; 4'b0000 means no write.
- m_inst_addr  in  32  PC of the storing instruction; trace only.
- m_data_rdata  out  32  read word at m_data_addr.
- trace_valid  out  1  trace FIFO non-empty.
- trace_ready  in  1  consumer accepts head entry this cycle.
- trace_pc  out  32  head entry PC.
- trace_addr  out  32  head entry word-aligned byte address ({addr[31:2],2'b00}).
- trace_data  out  32  head entry merged word after the write.
- trace_ovf  out  1  sticky: a trace entry was dropped.
- err_oor  out  1  sticky: an out-of-range access occurred.

## Operation
- Word index: addr[31:2]. An address is in range when the index is less than DEPTH.
- Read: m_data_rdata = RAM[index], combinational. Out-of-range reads return 32'h0 and set err_oor.
- Write: when byteen != 0 and the address is in range, each lane i with byteen[i]=1 replaces byte i of RAM[index] at the edge. Other lanes keep their value.
- Out-of-range write: the RAM is unchanged, err_oor is set, and no trace entry is pushed.
- Trace push: each in-range write pushes {m_inst_addr, aligned addr, merged word}. The merged word is computed from the pre-edge RAM contents and the enabled lanes.
- Trace pop: occurs when trace_valid && trace_ready.
- FIFO: circular buffer with read and write pointers of log2(TRACE_DEPTH)+1 bits. Empty when the pointers are equal; full when the MSBs differ and the low bits are equal.
- Push when full without a pop in the same cycle: the entry is dropped, trace_ovf is set, and the pointers do not move.
- Push and pop in the same cycle when full: the pop is applied first, then the push. Both succeed and occupancy is unchanged.
- Push and pop in the same cycle when empty: the push succeeds and the pop is ignored, because trace_valid was 0.
- Reset: all RAM words become 0. Both FIFO pointers, trace_ovf and err_oor become 0.
- Reset outputs: trace_valid=0, m_data_rdata=0, and trace_pc, trace_addr and trace_data are don't-care (driven from entry 0, which reset clears to 0).
- Reset takes priority over a same-cycle write or pop.

## Timing
- Read latency 0: a combinational path from m_data_addr to m_data_rdata.
- A read of an address written in the same cycle returns the old word. The new word is visible after the edge.
- A write is committed at edge N. trace_valid rises after edge N and is visible during cycle N+1.
- The head outputs are combinational from the FIFO storage at the read pointer. They are stable while trace_valid=1 and trace_ready=0.
- Sticky flags are set at the edge of the offending cycle and clear only on reset.
- Sustained throughput: one write plus one trace pop per cycle.

## Configuration
- DM_TRACE_EN defined: the trace FIFO, the handshake and trace_ovf operate as described above.
- DM_TRACE_EN undefined:
  - No FIFO storage is built.
  - trace_valid, trace_ovf and all trace_* data outputs are driven 0.
  - trace_ready is ignored.
  - RAM and err_oor behaviour are identical.

## Test plan
- Full store: after reset, write addr=0x10, wdata=0x12345678, byteen=4'hF, pc=0x3000. Required response: next-cycle rdata at 0x10 is 0x12345678, and trace entry = {0x3000, 0x10, 0x12345678}.
- Byte merge: starting from the word above, write addr=0x12, wdata=0x00AB0000, byteen=4'b0100. Required response: rdata = 0x12AB5678, and trace_data = 0x12AB5678.
- FIFO full and overflow, trace_ready=0, TRACE_DEPTH=8: issue 9 writes. Required response: 8 entries held and trace_ovf=1. Asserting trace_ready then pops the first 8 writes in order.
- Full with simultaneous push and pop: fill the FIFO, then write while trace_ready=1. Required response: trace_ovf stays 0 and occupancy stays 8.
- Out of range: write addr=DEPTH*4 with byteen=4'hF, then read the same address. Required response: rdata=0, err_oor=1, no trace entry, and address 0 unchanged.
- Reset mid-drain: reset asserted with 3 entries queued and a write in the same cycle. Required response: trace_valid=0 next cycle, all flags 0, and the written address reads 0.

Source files
------------

// File: rtl/dm_responder.sv
// Data-memory responder: word RAM with byte-merged writes, combinational reads,
// sticky range error and an optional store-trace FIFO enabled by `DM_TRACE_EN.
module dm_responder #(
  parameter int DEPTH       = 3072,
  parameter int TRACE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_ovf,
  output logic        err_oor
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem_q [DEPTH];
  logic [29:0]   wordIdx;
  logic [AW-1:0] memIdx;
  logic          inRange;
  logic          wrEn;
  logic [31:0]   oldWord;
  logic [31:0]   mergedWord;
  logic          errOor_q;

  assign wordIdx = m_data_addr[31:2];
  assign memIdx  = wordIdx[AW-1:0];
  assign inRange = (wordIdx < 30'(DEPTH));
  assign wrEn    = (m_data_byteen != 4'b0000) && inRange;

  // Out-of-range reads return zero; the same pre-edge word feeds the merge.
  assign oldWord      = inRange ? mem_q[memIdx] : 32'h0;
  assign m_data_rdata = oldWord;

  always_comb begin
    mergedWord = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (m_data_byteen[b]) begin
        mergedWord[8*b +: 8] = m_data_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (wrEn) begin
      mem_q[memIdx] <= mergedWord;
    end
  end

  // Every cycle presents an address, so any out-of-range address trips the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      errOor_q <= 1'b0;
    end else if (!inRange) begin
      errOor_q <= 1'b1;
    end
  end

  assign err_oor = errOor_q;

`ifdef DM_TRACE_EN
  localparam int PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

  logic [PW:0]  rdPtr_q, rdPtr_d;
  logic [PW:0]  wrPtr_q, wrPtr_d;
  logic [31:0]  tracePc_q   [TRACE_DEPTH];
  logic [31:0]  traceAddr_q [TRACE_DEPTH];
  logic [31:0]  traceData_q [TRACE_DEPTH];
  logic         traceOvf_q;
  logic         fifoEmpty;
  logic         fifoFull;
  logic         doPop;
  logic         doPush;
  logic         pushDrop;
  logic         unusedTrace;

  assign fifoEmpty = (rdPtr_q == wrPtr_q);
  assign fifoFull  = (rdPtr_q[PW] != wrPtr_q[PW]) &&
                     (rdPtr_q[PW-1:0] == wrPtr_q[PW-1:0]);

  // A pop frees the slot before the push lands, so full+pop+push still succeeds.
  assign doPop    = !fifoEmpty && trace_ready;
  assign doPush   = wrEn && (!fifoFull || doPop);
  assign pushDrop = wrEn && fifoFull && !doPop;

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    if (doPop) begin
      rdPtr_d = rdPtr_q + (PW+1)'(1);
    end
    if (doPush) begin
      wrPtr_d = wrPtr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      traceOvf_q <= 1'b0;
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        tracePc_q[i]   <= 32'h0;
        traceAddr_q[i] <= 32'h0;
        traceData_q[i] <= 32'h0;
      end
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      if (doPush) begin
        tracePc_q[wrPtr_q[PW-1:0]]   <= m_inst_addr;
        traceAddr_q[wrPtr_q[PW-1:0]] <= {m_data_addr[31:2], 2'b00};
        traceData_q[wrPtr_q[PW-1:0]] <= mergedWord;
      end
      if (pushDrop) begin
        traceOvf_q <= 1'b1;
      end
    end
  end

  assign trace_valid = !fifoEmpty;
  assign trace_pc    = tracePc_q[rdPtr_q[PW-1:0]];
  assign trace_addr  = traceAddr_q[rdPtr_q[PW-1:0]];
  assign trace_data  = traceData_q[rdPtr_q[PW-1:0]];
  assign trace_ovf   = traceOvf_q;
  assign unusedTrace = ^m_data_addr[1:0];
`else
  logic unusedTrace;

  assign trace_valid = 1'b0;
  assign trace_pc    = 32'h0;
  assign trace_addr  = 32'h0;
  assign trace_data  = 32'h0;
  assign trace_ovf   = 1'b0;
  assign unusedTrace = trace_ready ^ (^m_inst_addr) ^ (^m_data_addr[1:0]);
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: stimulus pushes expected reads/flags and
// trace entries into queues, a negedge monitor pops and compares them.
module tb_dm_responder;

`ifdef DM_TRACE_EN
  localparam bit TRACE_ON = 1'b1;
`else
  localparam bit TRACE_ON = 1'b0;
`endif

  localparam int DEPTH  = 3072;
  localparam int TDEPTH = 8;

  typedef struct {
    logic [31:0] rd;
    logic        oor;
    logic        ovf;
    logic        valid;
  } obs_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m_data_addr = 32'h0;
  logic [31:0] m_data_wdata = 32'h0;
  logic [3:0]  m_data_byteen = 4'h0;
  logic [31:0] m_inst_addr = 32'h0;
  logic [31:0] m_data_rdata;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_ovf;
  logic        err_oor;

  obs_t   obsQ[$];
  trace_t traceQ[$];
  logic   obsReq = 1'b0;
  int     compared = 0;
  int     mismatched = 0;

  // Reference model state advanced by the stimulus, one step per clock.
  int     mCount = 0;
  logic   mOvf = 1'b0;
  logic   mOor = 1'b0;

  dm_responder #(.DEPTH(DEPTH), .TRACE_DEPTH(TDEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .m_data_addr(m_data_addr),
    .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen),
    .m_inst_addr(m_inst_addr),
    .m_data_rdata(m_data_rdata),
    .trace_valid(trace_valid),
    .trace_ready(trace_ready),
    .trace_pc(trace_pc),
    .trace_addr(trace_addr),
    .trace_data(trace_data),
    .trace_ovf(trace_ovf),
    .err_oor(err_oor)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor samples mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (trace_valid && trace_ready) begin
      if (traceQ.size() == 0) begin
        cmp("unexpected trace pop", 32'h1, 32'h0);
      end else begin
        trace_t t;
        t = traceQ.pop_front();
        cmp("trace_pc", trace_pc, t.pc);
        cmp("trace_addr", trace_addr, t.addr);
        cmp("trace_data", trace_data, t.data);
      end
    end
    if (obsReq) begin
      if (obsQ.size() == 0) begin
        cmp("missing obs entry", 32'h1, 32'h0);
      end else begin
        obs_t o;
        o = obsQ.pop_front();
        cmp("rdata", m_data_rdata, o.rd);
        cmp("err_oor", {31'h0, err_oor}, {31'h0, o.oor});
        cmp("trace_ovf", {31'h0, trace_ovf}, {31'h0, o.ovf});
        cmp("trace_valid", {31'h0, trace_valid}, {31'h0, o.valid});
      end
    end
  end

  // One clock of stimulus; optionally queue an observation of the pre-edge outputs.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] pc,
                               input logic ready, input logic [31:0] expTrace,
                               input logic doChk, input logic [31:0] expR);
    logic inR;
    logic pop;
    logic push;
    m_data_addr   = addr;
    m_data_wdata  = wdata;
    m_data_byteen = be;
    m_inst_addr   = pc;
    trace_ready   = ready;
    inR  = (addr[31:2] < 30'(DEPTH));
    if (doChk) begin
      obsQ.push_back('{expR, mOor, mOvf, (mCount != 0)});
      obsReq = 1'b1;
    end
    pop  = (mCount != 0) && ready;
    push = TRACE_ON && (be != 4'h0) && inR;
    if (push) begin
      if (mCount == TDEPTH && !pop) begin
        mOvf = 1'b1;
      end else begin
        traceQ.push_back('{pc, {addr[31:2], 2'b00}, expTrace});
        mCount++;
      end
    end
    if (pop) mCount--;
    if (!inR) mOor = 1'b1;
    @(posedge clk);
    #1;
    obsReq = 1'b0;
  endtask

  task automatic checkOutput(input logic [31:0] addr, input logic ready, input logic [31:0] expR);
    applyStimulus(addr, 32'h0, 4'h0, 32'h0, ready, 32'h0, 1'b1, expR);
  endtask

  task automatic doReset(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    reset         = 1'b1;
    m_data_addr   = addr;
    m_data_wdata  = wdata;
    m_data_byteen = be;
    m_inst_addr   = 32'h9999_0000;
    trace_ready   = 1'b0;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    m_data_byteen = 4'h0;
    mCount = 0;
    mOvf   = 1'b0;
    mOor   = 1'b0;
    traceQ.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    $display("[TB] reset released, trace %s", TRACE_ON ? "enabled" : "disabled");
    checkOutput(32'h10, 1'b0, 32'h0);

    // Full store, then a single-lane merge; read-before-write in the merge cycle.
    applyStimulus(32'h10, 32'h1234_5678, 4'hF, 32'h3000, 1'b0, 32'h1234_5678, 1'b0, 32'h0);
    checkOutput(32'h10, 1'b0, 32'h1234_5678);
    applyStimulus(32'h12, 32'h00AB_0000, 4'b0100, 32'h3004, 1'b0, 32'h12AB_5678, 1'b1, 32'h1234_5678);
    checkOutput(32'h10, 1'b0, 32'h12AB_5678);
    repeat (2) checkOutput(32'h10, 1'b1, 32'h12AB_5678);
    checkOutput(32'h10, 1'b0, 32'h12AB_5678);

    // Full FIFO with simultaneous push and pop keeps occupancy and no overflow.
    for (int i = 0; i < TDEPTH; i++)
      applyStimulus(32'h200 + 32'(4*i), 32'hB000_0000 + 32'(i), 4'hF, 32'h4000 + 32'(4*i),
                    1'b0, 32'hB000_0000 + 32'(i), 1'b0, 32'h0);
    applyStimulus(32'h220, 32'hB000_0008, 4'hF, 32'h4020, 1'b1, 32'hB000_0008, 1'b0, 32'h0);
    checkOutput(32'h220, 1'b0, 32'hB000_0008);
    repeat (TDEPTH) checkOutput(32'h200, 1'b1, 32'hB000_0000);
    checkOutput(32'h204, 1'b0, 32'hB000_0001);

    // Nine writes into an eight-entry FIFO: the ninth is dropped, RAM still updated.
    for (int i = 0; i < TDEPTH + 1; i++)
      applyStimulus(32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, 32'h5000 + 32'(4*i),
                    1'b0, 32'hA000_0000 + 32'(i), 1'b0, 32'h0);
    checkOutput(32'h120, 1'b0, 32'hA000_0008);
    repeat (TDEPTH) checkOutput(32'h100, 1'b1, 32'hA000_0000);
    checkOutput(32'h11C, 1'b0, 32'hA000_0007);

    doReset(32'h0, 32'h0, 4'h0);
    checkOutput(32'h100, 1'b0, 32'h0);
    checkOutput(32'h10, 1'b0, 32'h0);

    // Out-of-range write leaves RAM alone; last in-range word still works.
    applyStimulus(32'h0, 32'hCAFE_F00D, 4'hF, 32'h6000, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h0);
    applyStimulus(32'(DEPTH*4), 32'hDEAD_BEEF, 4'hF, 32'h6004, 1'b0, 32'h0, 1'b1, 32'h0);
    checkOutput(32'(DEPTH*4), 1'b0, 32'h0);
    checkOutput(32'h0, 1'b0, 32'hCAFE_F00D);
    applyStimulus(32'(DEPTH*4-4), 32'h0000_1234, 4'b0011, 32'h6008, 1'b0, 32'h0000_1234, 1'b0, 32'h0);
    checkOutput(32'(DEPTH*4-4), 1'b0, 32'h0000_1234);
    repeat (2) checkOutput(32'h0, 1'b1, 32'hCAFE_F00D);
    checkOutput(32'h0, 1'b0, 32'hCAFE_F00D);

    // Reset mid-drain with a same-cycle write.
    for (int i = 0; i < 3; i++)
      applyStimulus(32'h40 + 32'(4*i), 32'h7700_0000 + 32'(i), 4'hF, 32'h7000 + 32'(4*i),
                    1'b0, 32'h7700_0000 + 32'(i), 1'b0, 32'h0);
    doReset(32'h4C, 32'h1111_1111, 4'hF);
    checkOutput(32'h4C, 1'b0, 32'h0);
    checkOutput(32'h40, 1'b1, 32'h0);

    repeat (2) checkOutput(32'h0, 1'b0, 32'h0);
    cmp("leftover trace entries", 32'(traceQ.size()), 32'h0);
    cmp("leftover obs entries", 32'(obsQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
